// File: rtl/gpio_inproc_pkg.sv
// gpio_inproc shared constants.
// Default sizing and debounce counter width helper.
package gpio_inproc_pkg;

    localparam int DEF_N_PADS     = 16;
    localparam int DEF_W_PRESCALE = 8;
    localparam int DEF_DB_TICKS   = 4;
    localparam int W_DBCNT        = $clog2(DEF_DB_TICKS + 1);

    function automatic int db_cnt_w(input int ticks);
        return $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One pad: 2-flop sync, tick-driven debounce, edge detect, sticky status.
// Ports: clk, rst_n, padin, tick, enables/clears in; sync/db/status out.
module gpio_debounce_bit
    import gpio_inproc_pkg::*;
#(
    parameter int DB_TICKS = DEF_DB_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic padin,
    input  logic tick,
    input  logic db_en,
    input  logic rise_en,
    input  logic fall_en,
    input  logic rise_clr,
    input  logic fall_clr,
    output logic pad_sync,
    output logic pad_db,
    output logic rise_stat,
    output logic fall_stat
);

    localparam int W_CNT = db_cnt_w(DB_TICKS);
    localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(DB_TICKS - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             prev;
    logic [W_CNT-1:0] cnt;
    logic             rise;
    logic             fall;

    assign pad_sync = sync_q2;
    assign rise     = pad_db & ~prev;
    assign fall     = ~pad_db & prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= padin;
            sync_q2 <= sync_q1;
        end
    end

    // A differing sample must persist for DB_TICKS consecutive ticks;
    // any agreeing tick restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            pad_db <= 1'b0;
        end else if (!db_en) begin
            cnt    <= '0;
            pad_db <= sync_q2;
        end else if (tick) begin
            if (sync_q2 == pad_db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                pad_db <= sync_q2;
            end else begin
                cnt <= cnt + W_CNT'(1);
            end
        end
    end

    // Set has priority over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev      <= 1'b0;
            rise_stat <= 1'b0;
            fall_stat <= 1'b0;
        end else begin
            prev      <= pad_db;
            rise_stat <= (rise_stat & ~rise_clr) | (rise & rise_en);
            fall_stat <= (fall_stat & ~fall_clr) | (fall & fall_en);
        end
    end

endmodule

// File: rtl/gpio_inproc.sv
// GPIO pad-input conditioning: shared prescaler, per-pad debounce, irq.
// Ports: clk, rst_n, padin/enables/clears in; sync, db, stat, irq out.
module gpio_inproc
    import gpio_inproc_pkg::*;
#(
    parameter int N_PADS     = DEF_N_PADS,
    parameter int W_PRESCALE = DEF_W_PRESCALE,
    parameter int DB_TICKS   = DEF_DB_TICKS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_PADS-1:0] padin,
    input  logic [N_PADS-1:0] db_en,
    input  logic [N_PADS-1:0] rise_en,
    input  logic [N_PADS-1:0] fall_en,
    input  logic [N_PADS-1:0] rise_clr,
    input  logic [N_PADS-1:0] fall_clr,
    output logic [N_PADS-1:0] pad_sync,
    output logic [N_PADS-1:0] pad_db,
    output logic [N_PADS-1:0] rise_stat,
    output logic [N_PADS-1:0] fall_stat,
    output logic              irq
);

    logic [W_PRESCALE-1:0] pre;
    logic                  tick;

    // Tick on the all-ones count, then wrap naturally to 0.
    assign tick = &pre;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else begin
            pre <= pre + W_PRESCALE'(1);
        end
    end

    for (genvar i = 0; i < N_PADS; i++) begin : g_pad
        gpio_debounce_bit #(
            .DB_TICKS (DB_TICKS)
        ) u_bit (
            .clk       (clk),
            .rst_n     (rst_n),
            .padin     (padin[i]),
            .tick      (tick),
            .db_en     (db_en[i]),
            .rise_en   (rise_en[i]),
            .fall_en   (fall_en[i]),
            .rise_clr  (rise_clr[i]),
            .fall_clr  (fall_clr[i]),
            .pad_sync  (pad_sync[i]),
            .pad_db    (pad_db[i]),
            .rise_stat (rise_stat[i]),
            .fall_stat (fall_stat[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |{rise_stat, fall_stat};
        end
    end

endmodule

// File: tb/tb_gpio_inproc.sv
// Self-checking bench for gpio_inproc.
// Random and directed stimulus against a cycle-level behavioural model.
module tb_gpio_inproc;

    localparam int N   = 16;
    localparam int WP  = 2;
    localparam int DBT = 4;
    localparam int P   = 1 << WP;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] padin;
    logic [N-1:0] db_en;
    logic [N-1:0] rise_en;
    logic [N-1:0] fall_en;
    logic [N-1:0] rise_clr;
    logic [N-1:0] fall_clr;
    logic [N-1:0] pad_sync;
    logic [N-1:0] pad_db;
    logic [N-1:0] rise_stat;
    logic [N-1:0] fall_stat;
    logic         irq;

    int checks;
    int errors;

    gpio_inproc #(
        .N_PADS     (N),
        .W_PRESCALE (WP),
        .DB_TICKS   (DBT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .padin     (padin),
        .db_en     (db_en),
        .rise_en   (rise_en),
        .fall_en   (fall_en),
        .rise_clr  (rise_clr),
        .fall_clr  (fall_clr),
        .pad_sync  (pad_sync),
        .pad_db    (pad_db),
        .rise_stat (rise_stat),
        .fall_stat (fall_stat),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference state
    logic [N-1:0] m_s1, m_s2, m_db, m_prev, m_rs, m_fs;
    logic         m_irq;
    int           m_run [N];
    int           m_edges;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp,
                         $time);
        end
    endtask

    task automatic m_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_prev = '0;
        m_rs = '0; m_fs = '0; m_irq = 1'b0; m_edges = 0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
    endtask

    // One clock edge of the reference, computed from old state.
    task automatic m_step();
        logic         tick;
        logic [N-1:0] n_db, rise, fall;
        tick = (m_edges % P) == P - 1;
        m_edges++;
        n_db = m_db;
        for (int i = 0; i < N; i++) begin
            if (!db_en[i]) begin
                n_db[i] = m_s2[i];
                m_run[i] = 0;
            end else if (tick) begin
                if (m_s2[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DBT) begin
                        n_db[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        rise   = m_db & ~m_prev;
        fall   = ~m_db & m_prev;
        m_irq  = |(m_rs | m_fs);
        m_rs   = (m_rs & ~rise_clr) | (rise & rise_en);
        m_fs   = (m_fs & ~fall_clr) | (fall & fall_en);
        m_prev = m_db;
        m_db   = n_db;
        m_s2   = m_s1;
        m_s1   = padin;
    endtask

    task automatic cmp_all();
        chk("pad_sync", 32'(pad_sync), 32'(m_s2));
        chk("pad_db", 32'(pad_db), 32'(m_db));
        chk("rise_stat", 32'(rise_stat), 32'(m_rs));
        chk("fall_stat", 32'(fall_stat), 32'(m_fs));
        chk("irq", 32'(irq), 32'(m_irq));
    endtask

    // Advance n cycles; returns at a negedge with outputs checked.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            m_step();
            @(negedge clk);
            cmp_all();
        end
    endtask

    task automatic pulse_clr(input logic [N-1:0] rc,
                             input logic [N-1:0] fc);
        rise_clr = rc;
        fall_clr = fc;
        step(1);
        rise_clr = '0;
        fall_clr = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        chk("rst_async", 32'({pad_sync, pad_db}), 32'd0);
        chk("rst_async_st", 32'({rise_stat, fall_stat, 15'd0, irq}),
            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_all();
    endtask

    initial begin
        int lat;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        padin = '0; db_en = '0; rise_en = '0; fall_en = '0;
        rise_clr = '0; fall_clr = '0;
        m_reset();
        #1;
        chk("reset_out", 32'({pad_sync, pad_db}), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Passthrough latency on pad 3
        rise_en = N'(1 << 3);
        step(2);
        padin[3] = 1'b1;
        step(2);
        chk("pt_sync_T2", 32'(pad_sync[3]), 32'd1);
        chk("pt_db_T2", 32'(pad_db[3]), 32'd0);
        step(1);
        chk("pt_db_T3", 32'(pad_db[3]), 32'd1);
        chk("pt_rs_T3", 32'(rise_stat[3]), 32'd0);
        step(1);
        chk("pt_rs_T4", 32'(rise_stat[3]), 32'd1);
        chk("pt_irq_T4", 32'(irq), 32'd0);
        step(1);
        chk("pt_irq_T5", 32'(irq), 32'd1);
        pulse_clr('1, '1);
        step(2);
        chk("pt_irq_clr", 32'(irq), 32'd0);

        // Debounce accept latency on pad 0
        db_en = 16'h0001;
        rise_en = 16'h0001;
        step(3);
        padin[0] = 1'b1;
        lat = 0;
        while (!pad_sync[0] && lat < 10) begin step(1); lat++; end
        chk("db_sync_seen", 32'(pad_sync[0]), 32'd1);
        lat = 0;
        while (!pad_db[0] && lat < 40) begin step(1); lat++; end
        chk("db_accept_lat", 32'(lat >= 13 && lat <= 16), 32'd1);
        step(2);
        pulse_clr('1, '1);

        // Glitch reject: drop low, then high again
        padin[0] = 1'b0;
        step(30);
        pulse_clr('1, '1);
        chk("gl_low", 32'(pad_db[0]), 32'd0);
        padin[0] = 1'b1;
        step(10);
        padin[0] = 1'b0;
        step(6);
        padin[0] = 1'b1;
        step(12);
        chk("gl_hold", 32'(pad_db[0]), 32'd0);
        chk("gl_rs_hold", 32'(rise_stat[0]), 32'd0);
        step(20);
        chk("gl_accept", 32'(pad_db[0]), 32'd1);
        chk("gl_rs_set", 32'(rise_stat[0]), 32'd1);
        pulse_clr('1, '1);
        step(2);

        // Clear versus set on pad 5
        db_en = '0;
        rise_en = N'(1 << 5);
        padin = '0;
        step(5);
        pulse_clr('1, '1);
        padin[5] = 1'b1;
        step(5);
        chk("cs_first", 32'(rise_stat[5]), 32'd1);
        padin[5] = 1'b0;
        step(4);
        padin[5] = 1'b1;
        lat = 0;
        while (!pad_db[5] && lat < 10) begin step(1); lat++; end
        rise_clr = N'(1 << 5);
        step(1);
        chk("cs_set_wins", 32'(rise_stat[5]), 32'd1);
        step(1);
        rise_clr = '0;
        chk("cs_clr_alone", 32'(rise_stat[5]), 32'd0);
        chk("cs_irq_1clk", 32'(irq), 32'd1);
        step(1);
        chk("cs_irq_2clk", 32'(irq), 32'd0);

        // Enable masking on pad 7
        rise_en = '0;
        fall_en = '0;
        padin[7] = 1'b1;
        step(6);
        padin[7] = 1'b0;
        step(6);
        chk("mask_lost", 32'(fall_stat[7]), 32'd0);
        fall_en = N'(1 << 7);
        step(3);
        chk("mask_no_retro", 32'(fall_stat[7]), 32'd0);
        padin[7] = 1'b1;
        step(6);
        padin[7] = 1'b0;
        step(6);
        chk("mask_later", 32'(fall_stat[7]), 32'd1);

        // Randomised phase
        for (int c = 0; c < 1500; c++) begin
            padin ^= N'($urandom & $urandom & $urandom & $urandom &
                        $urandom);
            if ($urandom_range(0, 63) == 0) db_en = N'($urandom);
            if ($urandom_range(0, 31) == 0) rise_en = N'($urandom);
            if ($urandom_range(0, 31) == 0) fall_en = N'($urandom);
            rise_clr = N'($urandom & $urandom & $urandom);
            fall_clr = N'($urandom & $urandom & $urandom);
            step(1);
        end
        rise_clr = '0;
        fall_clr = '0;

        // Reset mid-debounce with status set
        db_en = 16'h0001;
        rise_en = '1;
        fall_en = '1;
        padin = ~pad_db;
        step(11);
        do_reset();
        db_en = '0;
        padin = '1;
        step(3);
        chk("post_rst_rs3", 32'(rise_stat), 32'd0);
        step(1);
        chk("post_rst_rs4", 32'(rise_stat), 32'h0000_ffff);
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
